// File: rtl/svv_pkg.sv
// Shared defaults and sizing helpers for the status vector arbiter slice.
package svv_pkg;

    localparam int unsigned NREQ_DEFAULT  = 4;
    localparam int unsigned DEPTH_DEFAULT = 64;
    localparam int unsigned WIDTH_DEFAULT = 8;
    localparam int unsigned AFULL_MARGIN  = 4;

    // Occupancy counter must represent 0..depth inclusive.
    function automatic int unsigned count_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int unsigned index_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/svv_rr_arbiter.sv
// Combinational round-robin search: first asserted request at or after ptr, wrapping.
module svv_rr_arbiter
    import svv_pkg::*;
#(
    parameter int unsigned NREQ = NREQ_DEFAULT,
    parameter int unsigned IW   = index_width(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   idx
);

    logic [IW-1:0] cand;
    logic          found;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            cand = IW'((32'(ptr) + i) % NREQ);
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

endmodule

// File: rtl/status_vector_arbiter.sv
// Round-robin push arbiter in front of a status value vector, with occupancy tracking.
// Optional almost-full flag enabled by defining SVA_ALMOST_FULL_EN.
module status_vector_arbiter
    import svv_pkg::*;
#(
    parameter int unsigned NREQ      = NREQ_DEFAULT,
    parameter int unsigned DEPTH     = DEPTH_DEFAULT,
    parameter int unsigned WIDTH     = WIDTH_DEFAULT,
    parameter int unsigned AFULL_THR = DEPTH - AFULL_MARGIN,
    localparam int unsigned CW       = count_width(DEPTH),
    localparam int unsigned IW       = index_width(NREQ)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [NREQ-1:0]       req_valid_i,
    input  logic [NREQ*WIDTH-1:0] req_value_i,
    output logic [NREQ-1:0]       req_ready_o,
    input  logic                  cons_pull_i,
    output logic                  svv_push_o,
    output logic [WIDTH-1:0]      svv_value_o,
    output logic                  svv_pull_o,
    input  logic                  svv_valid_i,
    input  logic                  svv_full_i,
    output logic [CW-1:0]         count_o,
    output logic [IW-1:0]         grant_id_o
`ifdef SVA_ALMOST_FULL_EN
    ,
    output logic                  almost_full_o
`endif
);

    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic [IW-1:0]    rr_q;
    logic [IW-1:0]    rr_next;
    logic             push_q;
    logic [WIDTH-1:0] value_q;
    logic [IW-1:0]    grant_id_q;

    logic [NREQ-1:0]  rr_grant;
    logic [IW-1:0]    rr_idx;
    logic [WIDTH-1:0] winner_value;
    logic             accept;
    logic             transfer;

    svv_rr_arbiter #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr (
        .req   (req_valid_i),
        .ptr   (rr_q),
        .grant (rr_grant),
        .idx   (rr_idx)
    );

    // The pending registered push already owns a slot; a same-cycle pull grants no credit.
    assign accept       = ({1'b0, count_q} + {{CW{1'b0}}, push_q}) < (CW+1)'(DEPTH);
    assign req_ready_o  = (accept && !rst_i) ? rr_grant : '0;
    assign transfer     = |req_ready_o;
    assign winner_value = req_value_i[rr_idx*WIDTH +: WIDTH];
    assign rr_next      = (rr_idx == IW'(NREQ-1)) ? '0 : rr_idx + IW'(1);

    assign svv_pull_o   = cons_pull_i & svv_valid_i & ~rst_i;

    assign svv_push_o   = push_q;
    assign svv_value_o  = value_q;
    assign count_o      = count_q;
    assign grant_id_o   = grant_id_q;

    // A pull against an empty vector is ignored by the vector, so push wins.
    always_comb begin
        count_d = count_q;
        case ({push_q, svv_pull_o})
            2'b10: if (count_q != CW'(DEPTH)) count_d = count_q + CW'(1);
            2'b01: if (count_q != '0)         count_d = count_q - CW'(1);
            2'b11: if (count_q == '0)         count_d = CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_q       <= '0;
            count_q    <= '0;
            push_q     <= 1'b0;
            value_q    <= '0;
            grant_id_q <= '0;
        end else begin
            count_q <= count_d;
            push_q  <= transfer;
            if (transfer) begin
                value_q    <= winner_value;
                grant_id_q <= rr_idx;
                rr_q       <= rr_next;
            end
        end
    end

`ifdef SVA_ALMOST_FULL_EN
    logic af_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            af_q <= 1'b0;
        end else begin
            af_q <= (32'(count_q) >= AFULL_THR);
        end
    end

    assign almost_full_o = af_q;
`endif

    a_no_push_into_full: assert property (@(posedge clk_i) disable iff (rst_i)
        !(push_q && svv_full_i && !svv_pull_o));

    a_count_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
        !(push_q && !svv_pull_o && count_q == CW'(DEPTH)));

    a_count_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
        !(svv_pull_o && !push_q && count_q == '0));

    a_ready_onehot: assert property (@(posedge clk_i)
        $onehot0(req_ready_o) && ((req_ready_o & ~req_valid_i) == '0));

endmodule

// File: tb/tb_status_vector_arbiter.sv
// Scoreboard bench: random pushes/pulls checked against a queue-based vector model.
module tb_status_vector_arbiter;

    localparam int unsigned NREQ  = 4;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned WIDTH = 8;
    localparam int unsigned AFT   = 6;
    localparam int unsigned CW    = $clog2(DEPTH + 1);
    localparam int unsigned IW    = $clog2(NREQ);

    logic                  clk = 1'b0;
    logic                  rst_i;
    logic [NREQ-1:0]       req_valid_i;
    logic [NREQ*WIDTH-1:0] req_value_i;
    logic [NREQ-1:0]       req_ready_o;
    logic                  cons_pull_i;
    logic                  svv_push_o;
    logic [WIDTH-1:0]      svv_value_o;
    logic                  svv_pull_o;
    logic                  svv_valid_i;
    logic                  svv_full_i;
    logic [CW-1:0]         count_o;
    logic [IW-1:0]         grant_id_o;
`ifdef SVA_ALMOST_FULL_EN
    logic                  almost_full_o;
`endif

    always #5 clk = ~clk;

    status_vector_arbiter #(
        .NREQ      (NREQ),
        .DEPTH     (DEPTH),
        .WIDTH     (WIDTH),
        .AFULL_THR (AFT)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .req_valid_i (req_valid_i),
        .req_value_i (req_value_i),
        .req_ready_o (req_ready_o),
        .cons_pull_i (cons_pull_i),
        .svv_push_o  (svv_push_o),
        .svv_value_o (svv_value_o),
        .svv_pull_o  (svv_pull_o),
        .svv_valid_i (svv_valid_i),
        .svv_full_i  (svv_full_i),
        .count_o     (count_o),
        .grant_id_o  (grant_id_o)
`ifdef SVA_ALMOST_FULL_EN
        ,
        .almost_full_o (almost_full_o)
`endif
    );

    typedef struct {
        int               stamp;
        int               id;
        logic [WIDTH-1:0] val;
    } exp_t;

    exp_t             exp_q[$];
    logic [WIDTH-1:0] vec[$];
    logic [WIDTH-1:0] hist[$];
    int               m_rr   = 0;
    int               m_push = 0;
    bit               af_exp = 1'b0;
    int               cyc    = 0;
    int               xfers  = 0;
    int               checks = 0;
    int               passes = 0;
    exp_t             mon_e;
    logic [WIDTH-1:0] last_val = '0;
    int               last_id  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: every registered push must match the oldest outstanding grant.
    always @(negedge clk) begin
        if (rst_i) begin
            exp_q.delete();
            last_val = '0;
            last_id  = 0;
        end else if (svv_push_o) begin
            if (exp_q.size() == 0) begin
                check("unexpected_push", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check("push_latency", cyc, mon_e.stamp);
                check("push_value", svv_value_o, mon_e.val);
                check("push_grant_id", grant_id_o, mon_e.id);
                last_val = mon_e.val;
                last_id  = mon_e.id;
            end
        end else begin
            check("value_hold", svv_value_o, last_val);
            check("grant_id_hold", grant_id_o, last_id);
        end
    end

    // One clock of stimulus; entered and left 1 time unit after a rising edge.
    task automatic step(input logic [NREQ-1:0] v, input bit pull, input bit rst);
        logic [NREQ-1:0]  exp_rdy;
        int               win;
        bit               acc;
        bit               dpush;
        bit               dpull;
        logic [WIDTH-1:0] pv;
        logic [WIDTH-1:0] pulled;
        logic [WIDTH-1:0] oldest;
        rst_i       = rst;
        req_valid_i = v;
        cons_pull_i = pull;
        for (int k = 0; k < NREQ; k++) req_value_i[k*WIDTH +: WIDTH] = WIDTH'($urandom);
        svv_valid_i = (vec.size() > 0);
        svv_full_i  = (vec.size() == DEPTH);
        @(negedge clk);
        acc = !rst && ((vec.size() + m_push) < DEPTH);
        win = -1;
        for (int i = 0; i < NREQ; i++) begin
            int c;
            c = (m_rr + i) % NREQ;
            if (win < 0 && v[c]) win = c;
        end
        exp_rdy = '0;
        if (acc && win >= 0) exp_rdy[win] = 1'b1;
        check("req_ready", req_ready_o, exp_rdy);
        check("svv_pull", svv_pull_o, pull && vec.size() > 0 && !rst);
        check("count", count_o, vec.size());
        check("push_into_full", svv_push_o && svv_full_i && !svv_pull_o, 0);
`ifdef SVA_ALMOST_FULL_EN
        if (!rst) check("almost_full", almost_full_o, af_exp);
`endif
        if (|(req_ready_o & req_valid_i)) xfers++;
        dpush = svv_push_o;
        dpull = svv_pull_o;
        pv    = svv_value_o;
        if (acc && win >= 0) begin
            exp_q.push_back('{cyc + 1, win, req_value_i[win*WIDTH +: WIDTH]});
            hist.push_back(req_value_i[win*WIDTH +: WIDTH]);
            m_rr   = (win + 1) % NREQ;
            m_push = 1;
        end else begin
            m_push = 0;
        end
        @(posedge clk);
        if (rst) begin
            vec.delete();
            hist.delete();
            m_rr   = 0;
            m_push = 0;
            af_exp = 1'b0;
        end else begin
            af_exp = (vec.size() >= AFT);
            if (dpull && vec.size() > 0) begin
                pulled = vec.pop_front();
                oldest = (hist.size() > 0) ? hist.pop_front() : '0;
                check("pulled_oldest", pulled, oldest);
            end
            if (dpush) vec.push_back(pv);
        end
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 4; i++) step('0, 1'b1, 1'b0);
    endtask

    initial begin
        rst_i       = 1'b1;
        req_valid_i = '0;
        req_value_i = '0;
        cons_pull_i = 1'b0;
        svv_valid_i = 1'b0;
        svv_full_i  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        repeat (2) step('0, 1'b0, 1'b1);
        check("reset_count", count_o, 0);
        check("reset_push", svv_push_o, 0);
        check("reset_grant_id", grant_id_o, 0);
        check("reset_value", svv_value_o, 0);

        // All requesters busy on an empty vector: strict rotation until full.
        repeat (8) step('1, 1'b0, 1'b0);
        step('0, 1'b0, 1'b0);
        check("fill_count", count_o, 8);
        repeat (2) step('1, 1'b0, 1'b0);
        drain();

        // Single requester, no consumer: exactly DEPTH transfers then stall.
        xfers = 0;
        repeat (DEPTH + 6) step(4'b0100, 1'b0, 1'b0);
        check("single_req_transfers", xfers, DEPTH);
        drain();

        // Transfer and pull on an empty vector: the pull is masked.
        step(4'b0001, 1'b1, 1'b0);
        step('0, 1'b0, 1'b0);
        check("empty_pull_count", count_o, 1);

        // Occupancy 3 with a push and a pull together stays at 3.
        repeat (2) step(4'b0001, 1'b0, 1'b0);
        step('0, 1'b0, 1'b0);
        check("three_count", count_o, 3);
        step(4'b0010, 1'b0, 1'b0);
        step('0, 1'b1, 1'b0);
        check("push_pull_count", count_o, 3);
        drain();

        // Reset while a push is pending at occupancy 5.
        repeat (6) step('1, 1'b0, 1'b0);
        check("pre_reset_count", count_o, 5);
        check("pre_reset_push", svv_push_o, 1);
        step('1, 1'b0, 1'b1);
        check("post_reset_count", count_o, 0);
        check("post_reset_push", svv_push_o, 0);
        step('1, 1'b0, 1'b0);
        check("restart_grant0", grant_id_o, 0);
        step('1, 1'b0, 1'b0);
        check("restart_grant1", grant_id_o, 1);
        drain();

        // Six pushes to cross the almost-full threshold.
        repeat (6) step(4'b1000, 1'b0, 1'b0);
        repeat (3) step('0, 1'b0, 1'b0);
        drain();

        for (int n = 0; n < 400; n++) begin
            step(NREQ'($urandom_range(0, 15)), ($urandom_range(0, 9) < 4),
                 ($urandom_range(0, 63) == 0));
        end

        repeat (4) step('0, 1'b0, 1'b0);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
